// File: rtl/instr_prefetch_queue_if.sv
// Fetch-side bundle: redirect command, decode stream (out_*) and the single-request memory port.
// The master modport is the prefetch queue; the slave modport is the core/memory environment.
interface instr_prefetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        out_valid;
  logic [31:0] out_addr;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  modport master (
    input  redirect, redirect_addr, out_ready, mem_ack, mem_data,
    output out_valid, out_addr, out_instr, mem_req, mem_addr
  );

  modport slave (
    output redirect, redirect_addr, out_ready, mem_ack, mem_data,
    input  out_valid, out_addr, out_instr, mem_req, mem_addr
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: keeps up to DEPTH fetched {addr, instr} pairs ahead of decode,
// with one outstanding memory request and flush/restart on redirect.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic                    clk,
  input logic                    rst_n,
  instr_prefetch_queue_if.master bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e             state_q;
  logic               mem_req_q;
  logic [31:0]        mem_addr_q;
  logic [31:0]        fetch_pc_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [31:0]        addr_mem_q  [DEPTH];
  logic [31:0]        instr_mem_q [DEPTH];

  logic        push;
  logic        pop;
  logic        has_room;
  logic [31:0] target_pc;
  logic [31:0] pc_inc;

  assign target_pc = bus.redirect_addr & ~32'h3;
  assign pc_inc    = fetch_pc_q + 32'd4;
  assign pop       = (count_q != '0) && bus.out_ready;
  assign push      = (state_q == WAIT) && bus.mem_ack && !bus.redirect;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (bus.redirect) count_d = '0;
  end

  // A request is only launched when its result is guaranteed a slot, so pushes never overflow.
  assign has_room = (count_d < CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.redirect) begin
            fetch_pc_q <= target_pc;
            mem_addr_q <= target_pc;
            mem_req_q  <= 1'b1;
            state_q    <= WAIT;
          end else if (has_room) begin
            mem_addr_q <= fetch_pc_q;
            mem_req_q  <= 1'b1;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.redirect) begin
            fetch_pc_q <= target_pc;
            if (bus.mem_ack) begin
              mem_addr_q <= target_pc;
            end else begin
              // The pending request cannot be withdrawn; its data is dropped on arrival.
              state_q <= DROP;
            end
          end else if (bus.mem_ack) begin
            fetch_pc_q <= pc_inc;
            if (has_room) begin
              mem_addr_q <= pc_inc;
            end else begin
              mem_req_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        DROP: begin
          if (bus.mem_ack) begin
            fetch_pc_q <= bus.redirect ? target_pc : fetch_pc_q;
            mem_addr_q <= bus.redirect ? target_pc : fetch_pc_q;
            state_q    <= WAIT;
          end else if (bus.redirect) begin
            fetch_pc_q <= target_pc;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_q == PTR_W'(gi))) begin
          addr_mem_q[gi]  <= mem_addr_q;
          instr_mem_q[gi] <= bus.mem_data;
        end
      end
    end
  endgenerate

  assign bus.out_valid = (count_q != '0);
  assign bus.out_addr  = bus.out_valid ? addr_mem_q[rd_ptr_q]  : 32'h0;
  assign bus.out_instr = bus.out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Fetch front-end between the core's program counter and a variable-latency instruction memory. It keeps a small FIFO of prefetched (address, instruction) pairs and drives a one-outstanding-request req/ack memory port. It presents a valid/ready stream to instruction decode. On a taken branch or jump redirect it flushes all buffered and in-flight fetches and restarts at the target address.

## Interface
- DEPTH, 4, number of queue entries (power of two, ≥2)
- RESET_PC, 32'h0, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- redirect  in  1  flush the queue and restart fetch at redirect_addr
- redirect_addr  in  32  new fetch address; bits [1:0] ignored (treated as 0)
- out_valid  out  1  queue head holds a valid instruction
- out_addr  out  32  address of the head instruction
- out_instr  out  32  head instruction word
- out_ready  in  1  consumer accepts the head this cycle (pop when out_valid && out_ready)
- mem_req  out  1  fetch request (registered)
- mem_addr  out  32  word-aligned fetch address (registered, stable while mem_req=1)
- mem_ack  in  1  memory returns mem_data for the current request; meaningful only while mem_req=1
- mem_data  in  32  instruction word, valid when mem_ack=1

## Operation
- State: fetch_pc (32b), FIFO of DEPTH entries {addr, instr}, rd/wr pointers, count (0..DEPTH), FSM {IDLE, WAIT, DROP}.
- IDLE: mem_req=0. If count_next < DEPTH, then next cycle mem_req=1, mem_addr=fetch_pc, and the FSM enters WAIT.
- WAIT: mem_req is held, with mem_addr stable. On mem_ack:
  - push {mem_addr, mem_data};
  - fetch_pc += 4;
  - if the post-push count_next < DEPTH, stay in WAIT with mem_addr = new fetch_pc (back-to-back); else go to IDLE with mem_req=0.
- Pop and push in the same cycle are legal. count is unchanged and both pointers advance.
- A push into a full queue cannot occur, because a request is only issued when a free slot is guaranteed. Pops cannot un-guarantee the slot.
- Redirect handling:
  - redirect in IDLE: clear the queue, set fetch_pc = {redirect_addr[31:2], 2'b00}, and issue a request on the next cycle.
  - redirect in WAIT without mem_ack: the request cannot be withdrawn. Clear the queue, load fetch_pc, go to DROP, and keep mem_req/mem_addr unchanged.
  - DROP: on mem_ack, discard mem_data (no push). Next cycle issue the request at fetch_pc and enter WAIT.
  - redirect in WAIT or DROP with mem_ack in the same cycle: discard data, load fetch_pc, and issue the new request the next cycle (WAIT).
  - redirect in DROP without ack: reload fetch_pc only and stay in DROP.
  - redirect with a simultaneous pop: redirect wins, and the queue is empty next cycle. The popped instruction is still considered consumed by the consumer, but that is the consumer's concern.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. full/empty are derived from count.
- fetch_pc wraps 32'hFFFF_FFFC → 32'h0 with no error.
- Reset (rst_n=0 at an edge) sets:
  - mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC;
  - count=0, pointers=0, out_valid=0, FSM=IDLE.
- out_addr/out_instr read as 0 when empty.
- Reset mid-request: mem_req drops next cycle. The memory must tolerate an abandoned request, and a stray ack after reset is ignored because mem_req=0.

## Timing
- Request issue: the first mem_req rises in the cycle after the reset edge is released.
- Ack to visibility: mem_ack sampled at edge k makes out_valid=1 from edge k onward. out_instr is a registered FIFO output, never combinational from mem_data.
- Throughput: with mem_ack tied to 1 and out_ready=1, one instruction is delivered per cycle at steady state and mem_addr increments by 4 every cycle.
- Redirect to new request: mem_req with the new address appears 1 cycle after redirect (IDLE, or same-cycle ack). In DROP it appears 1 cycle after the pending ack.
- Redirect to first valid output: new request cycle + memory latency.
- out_valid falls the cycle after a redirect edge.
- Outputs out_*, mem_req and mem_addr all change only on clock edges.

## Test plan
- **Reset and fill:** RESET_PC=0, mem_ack=1 constant, out_ready=0.
  - mem_addr sequence is 0,4,8,12.
  - mem_req drops after the 4th ack.
  - count=4, out_addr=0.
  - No 5th request.
- **Streaming:** mem_ack=1, out_ready=1, memory returns mem_data=addr^32'hA5A5_0000.
  - After 2 cycles, one pop per cycle.
  - out_addr increments by 4 with matching out_instr.
  - No gaps over 20 cycles.
- **Slow memory:** ack 3 cycles after each request, out_ready=1.
  - mem_addr is held stable during the wait.
  - One instruction every 3 cycles with addresses 0,4,8.
- **Redirect during wait:** request at 0x10 pending, redirect to 0x203.
  - The queue empties next cycle.
  - The ack for 0x10 (data 0xDEAD) is discarded.
  - The next request is 0x200.
  - The first out_addr is 0x200.
- **Redirect with same-cycle ack and pop:** queue holds 2 entries and mem_ack=1, out_ready=1, redirect=0x40 all fire in one cycle.
  - Next cycle out_valid=0, mem_addr=0x40.
  - The acked data never appears.
- **Reset mid-operation:** rst_n=0 while WAIT and count=3.
  - Next cycle mem_req=0, out_valid=0, mem_addr=RESET_PC.
  - After release, fetch restarts at RESET_PC.
